instr_encode_loader: RTL

- Encodes field-level command records (operation kind, rd, rs1, rs2, imm) into 32-bit RV32I instruction words.
- Writes the encoded words sequentially into instruction memory through a one-cycle write port.
- Performs the inverse of opcode decoding: it maps operation intent to opcode/funct3/funct7/immediate bit layout.
- Sits between the test/boot command source and the instruction memory. It is used to load programs before the CPU is released from reset.

---
 rtl/instr_encode_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instr_encode_loader.sv
// Loader that encodes field-level command records into RV32I instruction words
// and streams them into instruction memory, one word per two cycles.
module instr_encode_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_kind,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [11:0]       cmd_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W-2:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Handshake: a command is consumed on any rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only while in LOAD.
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W-2:0] DEPTH_W = (ADDR_W-1)'(DEPTH);

  state_t            state;
  logic [31:0]       enc;
  logic              legal;
  logic [ADDR_W-2:0] count_next;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^base_addr[1:0];
  assign count_next       = word_count + (ADDR_W-1)'(1);

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (cmd_kind)
      4'd0: enc = {7'b0000000, cmd_rs2, cmd_rs1, 3'b000, cmd_rd, 7'b0110011};
      4'd1: enc = {7'b0100000, cmd_rs2, cmd_rs1, 3'b000, cmd_rd, 7'b0110011};
      4'd2: enc = {7'b0000000, cmd_rs2, cmd_rs1, 3'b111, cmd_rd, 7'b0110011};
      4'd3: enc = {7'b0000000, cmd_rs2, cmd_rs1, 3'b110, cmd_rd, 7'b0110011};
      4'd4: enc = {cmd_imm, cmd_rs1, 3'b000, cmd_rd, 7'b0010011};
      4'd5: enc = {cmd_imm, cmd_rs1, 3'b010, cmd_rd, 7'b0000011};
      4'd6: enc = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], 7'b0100011};
      // cmd_imm carries branch offset bits [12:1], so index 10 is offset bit 11
      4'd7: enc = {cmd_imm[11], cmd_imm[9:4], cmd_rs2, cmd_rs1, 3'b000,
                   cmd_imm[3:0], cmd_imm[10], 7'b1100011};
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            imem_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
            word_count <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b1;
            cmd_ready  <= 1'b1;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          // A handshake takes priority; a coincident finish is dropped.
          if (cmd_valid) begin
            if (legal) begin
              imem_wdata <= enc;
              imem_we    <= 1'b1;
              cmd_ready  <= 1'b0;
              state      <= S_WRITE;
            end else begin
              err <= 1'b1;
            end
          end else if (finish) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_WRITE: begin
          imem_we    <= 1'b0;
          imem_addr  <= imem_addr + ADDR_W'(4);
          word_count <= count_next;
          if (count_next == DEPTH_W) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cmd_ready <= 1'b1;
            state     <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
